// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receiver and the
//               baud-tick generator: FSM state encoding, 16x oversampling
//               constants and the 3-sample majority helper.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Receiver frame states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    // Oversampling: 16 ticks per bit, bit value voted from ticks 7, 8 and 9
    localparam int unsigned OVS    = 16;
    localparam int unsigned SCNT_W = 4;
    localparam logic [SCNT_W-1:0] SMP_LO  = 4'd7;
    localparam logic [SCNT_W-1:0] SMP_MID = 4'd8;
    localparam logic [SCNT_W-1:0] SMP_HI  = 4'd9;
    localparam logic [SCNT_W-1:0] S_LAST  = 4'd15;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Oversample tick generator. A down-counter reloads from
//               div_i when it reaches zero; tick_o is high for the single
//               cycle the counter sits at zero, giving one tick every
//               div_i+1 clock cycles (div_i=0 -> tick every cycle).
// Ports       : clk6x   in  clock
//               resetn  in  asynchronous active-low reset
//               div_i   in  DIVW  cycles per tick minus 1
//               tick_o  out 1     one-cycle tick pulse
// Revision    : 1.0  initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIVW = 16
) (
    input  logic            clk6x,
    input  logic            resetn,
    input  logic [DIVW-1:0] div_i,
    output logic            tick_o
);

    logic [DIVW-1:0] cnt_q;

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (cnt_q == '0) begin
            cnt_q <= div_i;
        end else begin
            cnt_q <= cnt_q - DIVW'(1);
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with 16x oversampling feeding a byte FIFO
//               write port. Each good byte is presented on wport_o with a
//               one-cycle wenq_o strobe; a byte arriving while the FIFO is
//               full is dropped and flags an overrun.
// Ports       : clk6x       in  system clock
//               resetn      in  asynchronous active-low reset
//               rx_i        in  serial line, idle high, asynchronous
//               baud_div_i  in  clk6x cycles per oversample tick minus 1
//               wport_o     out received byte (holds last enqueued byte)
//               wenq_o      out one-cycle enqueue strobe
//               full_i      in  FIFO full flag
//               busy_o      out frame in progress
//               ferr_o      out sticky framing error
//               ovr_o       out sticky overrun
//               clr_err_i   in  one-cycle pulse clearing ferr_o / ovr_o
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIVW     = 16,
    parameter int BITWIDTH = 8
) (
    input  logic                clk6x,
    input  logic                resetn,
    input  logic                rx_i,
    input  logic [DIVW-1:0]     baud_div_i,
    output logic [BITWIDTH-1:0] wport_o,
    output logic                wenq_o,
    input  logic                full_i,
    output logic                busy_o,
    output logic                ferr_o,
    output logic                ovr_o,
    input  logic                clr_err_i
);

    localparam int unsigned IDXW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BITWIDTH - 1);

    // ------------------------------------------------------------------------
    // Synchroniser (resets to the idle-high line level)
    // ------------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------------
    // Oversample tick
    // ------------------------------------------------------------------------
    logic w_tick;

    uart_baud_tick #(
        .DIVW (DIVW)
    ) u_tick (
        .clk6x  (clk6x),
        .resetn (resetn),
        .div_i  (baud_div_i),
        .tick_o (w_tick)
    );

    // ------------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------------
    rx_state_e           state_q,   state_d;
    logic [SCNT_W-1:0]   s_cnt_q,   s_cnt_d;
    logic [IDXW-1:0]     bit_idx_q, bit_idx_d;
    logic [BITWIDTH-1:0] shreg_q,   shreg_d;
    logic                smp_lo_q,  smp_lo_d;
    logic                smp_mid_q, smp_mid_d;
    logic                pend_q,    pend_d;    // byte ready, present next cycle
    logic [BITWIDTH-1:0] wport_q,   wport_d;
    logic                ferr_q,    ferr_d;
    logic                ovr_q,     ovr_d;

    logic w_maj;
    logic w_ferr_set;
    logic w_wenq;
    logic w_ovr_set;

    // The third vote is the live sample at s_cnt=9, the decision tick.
    assign w_maj = maj3(smp_lo_q, smp_mid_q, rx_s_q);

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            s_cnt_q   <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            smp_lo_q  <= 1'b1;
            smp_mid_q <= 1'b1;
            pend_q    <= 1'b0;
            wport_q   <= '0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            smp_lo_q  <= smp_lo_d;
            smp_mid_q <= smp_mid_d;
            pend_q    <= pend_d;
            wport_q   <= wport_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        s_cnt_d    = s_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        smp_lo_d   = smp_lo_q;
        smp_mid_d  = smp_mid_q;
        pend_d     = 1'b0;
        w_ferr_set = 1'b0;

        if (w_tick) begin
            if (state_q != IDLE) begin
                s_cnt_d = s_cnt_q + SCNT_W'(1);
                if (s_cnt_q == SMP_LO) begin
                    smp_lo_d = rx_s_q;
                end
                if (s_cnt_q == SMP_MID) begin
                    smp_mid_d = rx_s_q;
                end
            end

            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        s_cnt_d = '0;
                    end
                end
                START: begin
                    if ((s_cnt_q == SMP_HI) && w_maj) begin
                        state_d = IDLE;           // start bit was a glitch
                    end else if (s_cnt_q == S_LAST) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
                DATA: begin
                    if (s_cnt_q == SMP_HI) begin
                        // LSB first: new bit enters at the top and shifts down
                        shreg_d = {w_maj, shreg_q} >> 1;
                    end
                    if (s_cnt_q == S_LAST) begin
                        if (bit_idx_q == LAST_IDX) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + IDXW'(1);
                        end
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a following start edge is caught
                    if (s_cnt_q == SMP_HI) begin
                        if (w_maj) begin
                            state_d = IDLE;
                            pend_d  = 1'b1;
                        end else begin
                            state_d    = BREAK;
                            w_ferr_set = 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // full_i is looked at only in the presentation cycle, and gates the
    // strobe combinationally so wenq_o can never coincide with full_i=1.
    assign w_wenq    = pend_q & ~full_i;
    assign w_ovr_set = pend_q &  full_i;

    always_comb begin
        wport_d = w_wenq ? shreg_q : wport_q;
        // A set event outranks a simultaneous clear
        ferr_d  = w_ferr_set | (ferr_q & ~clr_err_i);
        ovr_d   = w_ovr_set  | (ovr_q  & ~clr_err_i);
    end

    // The byte is visible in the strobe cycle itself; otherwise the last
    // enqueued byte is held, so a dropped byte never disturbs wport_o.
    assign wport_o = w_wenq ? shreg_q : wport_q;
    assign wenq_o  = w_wenq;
    assign busy_o  = (state_q != IDLE);
    assign ferr_o  = ferr_q;
    assign ovr_o   = ovr_q;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Directed frames are driven
//               on rx_i; expected bytes are queued when a frame is sent and
//               a monitor thread pops and compares on every wenq_o strobe.
//               A four-entry FIFO model collects strobed bytes and drives
//               full_i.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    logic        clk6x = 1'b0;
    logic        resetn;
    logic        rx_i;
    logic [15:0] baud_div_i;
    logic [7:0]  wport_o;
    logic        wenq_o;
    logic        full_i;
    logic        busy_o;
    logic        ferr_o;
    logic        ovr_o;
    logic        clr_err_i;

    logic        full_force = 1'b0;
    logic        fifo_full  = 1'b0;
    assign full_i = full_force | fifo_full;

    uart_rx #(
        .DIVW     (16),
        .BITWIDTH (8)
    ) dut (
        .clk6x      (clk6x),
        .resetn     (resetn),
        .rx_i       (rx_i),
        .baud_div_i (baud_div_i),
        .wport_o    (wport_o),
        .wenq_o     (wenq_o),
        .full_i     (full_i),
        .busy_o     (busy_o),
        .ferr_o     (ferr_o),
        .ovr_o      (ovr_o),
        .clr_err_i  (clr_err_i)
    );

    always #5 clk6x = ~clk6x;

    localparam int BIT_CYC = 48;    // baud_div_i=2 -> 3 cycles/tick * 16

    int n_tests       = 0;
    int n_fail        = 0;
    int cyc           = 0;
    int wenq_cnt      = 0;
    int last_wenq_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fifo_q[$];

    always @(posedge clk6x) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pops the scoreboard on every strobe and keeps the FIFO model current.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk6x);
            if (wenq_o === 1'b1) begin
                wenq_cnt++;
                last_wenq_cyc = cyc;
                check("wenq_while_full", full_i, 1'b0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_wenq: got byte 0x%02h, expected no strobe", wport_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wport_byte", wport_o, e);
                end
                fifo_q.push_back(wport_o);
                // full rises after the clock edge, as a real FIFO would
                @(posedge clk6x);
                #1 fifo_full = (fifo_q.size() >= 4);
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk6x);
    endtask

    // Drive one 8N1 frame; rx_i changes on negedges. Returns start cycle and
    // busy_o sampled in the middle of data bit 3.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                             output int t_start, output logic busy_mid);
        @(negedge clk6x);
        rx_i    = 1'b0;
        t_start = cyc;
        wait_cyc(BIT_CYC - 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk6x);
            rx_i = b[i];
            if (i == 3) begin
                wait_cyc(BIT_CYC / 2);
                busy_mid = busy_o;
                wait_cyc(BIT_CYC - 1 - BIT_CYC / 2);
            end else begin
                wait_cyc(BIT_CYC - 1);
            end
        end
        @(negedge clk6x);
        rx_i = stop_bit;
        wait_cyc(BIT_CYC - 1);
    endtask

    task automatic pulse_clr();
        @(negedge clk6x);
        clr_err_i = 1'b1;
        @(negedge clk6x);
        clr_err_i = 1'b0;
    endtask

    initial begin
        int   t0;
        int   base;
        int   k;
        logic bm;
        logic [7:0] got;
        logic [7:0] order [4];

        order[0] = 8'h12; order[1] = 8'h34; order[2] = 8'h56; order[3] = 8'h78;

        resetn     = 1'b0;
        rx_i       = 1'b1;
        baud_div_i = 16'd2;
        clr_err_i  = 1'b0;

        fork
            monitor();
        join_none

        // 1. reset state
        wait_cyc(5);
        check("rst_wport", wport_o, 8'h00);
        check("rst_wenq",  wenq_o,  1'b0);
        check("rst_busy",  busy_o,  1'b0);
        check("rst_ferr",  ferr_o,  1'b0);
        check("rst_ovr",   ovr_o,   1'b0);
        @(negedge clk6x);
        resetn = 1'b1;
        wait_cyc(20);

        // 2. single good frame
        base = wenq_cnt;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, t0, bm);
        check("a5_busy_mid",   bm, 1'b1);
        check("a5_strobes",    wenq_cnt - base, 1);
        check("a5_latency_ok", ((last_wenq_cyc - t0) <= 470) ? 1 : 0, 1);
        wait_cyc(10);
        check("a5_busy_after", busy_o, 1'b0);

        // 3. short glitch: start detected, rejected at the vote
        base = wenq_cnt;
        @(negedge clk6x);
        rx_i = 1'b0;
        wait_cyc(6);
        rx_i = 1'b1;
        k = 0;
        while (busy_o !== 1'b1 && k < 30) begin
            @(negedge clk6x);
            k++;
        end
        check("glitch_busy_rise", busy_o, 1'b1);
        k = 0;
        while (busy_o !== 1'b0 && k < 100) begin
            @(negedge clk6x);
            k++;
        end
        check("glitch_busy_fall", busy_o, 1'b0);
        wait_cyc(BIT_CYC);
        check("glitch_no_wenq", wenq_cnt - base, 0);
        check("glitch_no_ferr", ferr_o, 1'b0);

        // 4. framing error plus break, then recovery
        base = wenq_cnt;
        send_byte(8'h3C, 1'b0, t0, bm);
        wait_cyc(2 * BIT_CYC);
        @(negedge clk6x);
        rx_i = 1'b1;
        wait_cyc(2 * BIT_CYC);
        check("ferr_set",     ferr_o, 1'b1);
        check("ferr_no_wenq", wenq_cnt - base, 0);
        check("ferr_idle",    busy_o, 1'b0);
        base = wenq_cnt;
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1, t0, bm);
        wait_cyc(10);
        check("x55_strobes",     wenq_cnt - base, 1);
        check("ferr_still_set",  ferr_o, 1'b1);
        pulse_clr();
        check("ferr_cleared",    ferr_o, 1'b0);

        // 5. overrun
        base = wenq_cnt;
        full_force = 1'b1;
        send_byte(8'h12, 1'b1, t0, bm);
        wait_cyc(10);
        check("ovr_set",       ovr_o, 1'b1);
        check("ovr_no_wenq",   wenq_cnt - base, 0);
        check("ovr_wport_held", wport_o, 8'h55);
        full_force = 1'b0;
        base = wenq_cnt;
        exp_q.push_back(8'h34);
        send_byte(8'h34, 1'b1, t0, bm);
        wait_cyc(10);
        check("x34_strobes",   wenq_cnt - base, 1);
        check("ovr_sticky",    ovr_o, 1'b1);
        check("x34_wport_hold", wport_o, 8'h34);
        pulse_clr();
        check("ovr_cleared",   ovr_o, 1'b0);

        // 6. four back-to-back frames fill the FIFO model
        fifo_q.delete();
        fifo_full = 1'b0;
        wait_cyc(20);
        for (int i = 0; i < 4; i++) exp_q.push_back(order[i]);
        for (int i = 0; i < 4; i++) send_byte(order[i], 1'b1, t0, bm);
        wait_cyc(10);
        check("fifo_count", fifo_q.size(), 4);
        check("fifo_full",  full_i, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (fifo_q.size() > 0) got = fifo_q.pop_front();
            else got = 8'hxx;
            check("fifo_order", got, order[i]);
        end
        fifo_full = 1'b0;

        // 5th frame aborted by reset after start + 3 data bits
        base = wenq_cnt;
        got  = 8'h9A;
        @(negedge clk6x);
        rx_i = 1'b0;
        wait_cyc(BIT_CYC - 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk6x);
            rx_i = got[i];
            wait_cyc(BIT_CYC - 1);
        end
        check("abort_busy_before", busy_o, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("abort_wport", wport_o, 8'h00);
        check("abort_wenq",  wenq_o,  1'b0);
        check("abort_busy",  busy_o,  1'b0);
        check("abort_ferr",  ferr_o,  1'b0);
        check("abort_ovr",   ovr_o,   1'b0);
        rx_i = 1'b1;
        wait_cyc(5);
        resetn = 1'b1;
        wait_cyc(12 * BIT_CYC);
        check("abort_no_wenq", wenq_cnt - base, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
